// File: rtl/audio_level_meter_pkg.sv
// Shared types and helpers for the audio level meter.
package audio_meter_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_PEAK = 2'd2
  } meter_mode_t;

  // Shift that maps LED segment index to its magnitude threshold.
  function automatic int led_shift(input int sample_w, input int led_log2);
    return sample_w - 1 - led_log2;
  endfunction

endpackage

// File: rtl/audio_level_meter_sat_abs.sv
// Combinational saturated magnitude of a signed W-bit sample, W-1 bit result.
module sat_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  output logic [W-2:0] mag
);

  always_comb begin
    if (!x[W-1]) begin
      mag = x[W-2:0];
    end else if (x[W-2:0] == '0) begin
      // Most negative value has no positive twin; clamp to full scale.
      mag = '1;
    end else begin
      mag = ~x[W-2:0] + 1'b1;
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: magnitude, channel max, raw/average/peak-hold
// level with decay, thermometer LED bar and held clip flag.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int CHANNELS     = 2,
  parameter int LED_LOG2     = 4,
  parameter int AVG_LOG2     = 8,
  parameter int HOLD_CYCLES  = 12500000,
  parameter int DECAY_PERIOD = 500000,
  parameter int DECAY_STEP   = 512,
  parameter int CLIP_THRESH  = 32000,
  parameter int CLIP_HOLD    = 25000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic [1:0]                   mode,
  input  logic                         peak_clear,
  output logic [(2**LED_LOG2)-1:0]     led_bar,
  output logic [SAMPLE_W-2:0]          level,
  output logic                         level_valid,
  output logic                         clip
);

  localparam int MAG_W    = SAMPLE_W - 1;
  localparam int NUM_LEDS = 2 ** LED_LOG2;
  localparam int SHIFT    = led_shift(SAMPLE_W, LED_LOG2);
  localparam int ACC_W    = MAG_W + AVG_LOG2;
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int DECAY_W  = $clog2(DECAY_PERIOD + 1);
  localparam int CLIP_W   = $clog2(CLIP_HOLD + 1);

  localparam logic [MAG_W-1:0]   CLIP_THRESH_V = MAG_W'(CLIP_THRESH);
  localparam logic [MAG_W-1:0]   DECAY_STEP_V  = MAG_W'(DECAY_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_V        = HOLD_W'(HOLD_CYCLES);
  localparam logic [DECAY_W-1:0] DECAY_LAST_V  = DECAY_W'(DECAY_PERIOD - 1);
  localparam logic [CLIP_W-1:0]  CLIP_HOLD_V   = CLIP_W'(CLIP_HOLD);

  logic [MAG_W-1:0]    mag_comb [CHANNELS];
  logic [MAG_W-1:0]    mag_q    [CHANNELS];
  logic                s1_valid_q;
  logic [MAG_W-1:0]    combined;
  logic                clip_hit;

  logic [MAG_W-1:0]    combined_q;
  logic                s2_valid_q;
  logic [ACC_W-1:0]    acc_d, acc_q, acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_d, avg_cnt_q;
  logic [MAG_W-1:0]    avg_d, avg_q;
  logic                avg_done_d, avg_done_q;
  logic [MAG_W-1:0]    peak_d, peak_q;
  logic [HOLD_W-1:0]   hold_d, hold_q;
  logic [DECAY_W-1:0]  decay_d, decay_q;
  logic [CLIP_W-1:0]   clip_timer_d, clip_timer_q;
  logic                clip_d, clip_q;
  logic [MAG_W-1:0]    level_d, level_q;
  logic [NUM_LEDS-1:0] led_bar_d, led_bar_q;
  logic                level_valid_d, level_valid_q;

  genvar gi;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_abs
      sat_abs #(.W(SAMPLE_W)) u_sat_abs (
        .x   (sample_data[gi*SAMPLE_W +: SAMPLE_W]),
        .mag (mag_comb[gi])
      );
    end
  endgenerate

  always_comb begin
    combined = mag_q[0];
    clip_hit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mag_q[c] > combined) combined = mag_q[c];
      if (mag_q[c] >= CLIP_THRESH_V) clip_hit = s1_valid_q;
    end
  end

  // Averager: sum a power-of-two window, truncating divide on the last value.
  always_comb begin
    acc_sum    = acc_q + ACC_W'(combined);
    acc_d      = acc_q;
    avg_cnt_d  = avg_cnt_q;
    avg_d      = avg_q;
    avg_done_d = 1'b0;
    if (s1_valid_q) begin
      avg_cnt_d = avg_cnt_q + 1'b1;
      if (avg_cnt_q == '1) begin
        avg_d      = MAG_W'(acc_sum >> AVG_LOG2);
        acc_d      = '0;
        avg_done_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_comb begin
    peak_d  = peak_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    if (peak_clear && s1_valid_q) begin
      peak_d  = combined;
      hold_d  = HOLD_V;
      decay_d = '0;
    end else if (peak_clear) begin
      peak_d  = '0;
      hold_d  = '0;
      decay_d = '0;
    end else if (s1_valid_q && (combined > peak_q)) begin
      peak_d  = combined;
      hold_d  = HOLD_V;
      decay_d = '0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else if (decay_q == DECAY_LAST_V) begin
      decay_d = '0;
      peak_d  = (peak_q > DECAY_STEP_V) ? (peak_q - DECAY_STEP_V) : '0;
    end else begin
      decay_d = decay_q + 1'b1;
    end
  end

  always_comb begin
    clip_timer_d = clip_timer_q;
    if (clip_hit) begin
      clip_timer_d = CLIP_HOLD_V;
    end else if (clip_timer_q != '0) begin
      clip_timer_d = clip_timer_q - 1'b1;
    end
    clip_d = clip_hit || (clip_timer_d != '0);
  end

  // Mode 3 falls through to raw.
  always_comb begin
    level_d       = combined_q;
    level_valid_d = s2_valid_q;
    case (mode)
      MODE_AVG: begin
        level_d       = avg_q;
        level_valid_d = avg_done_q;
      end
      MODE_PEAK: begin
        level_d       = peak_q;
        level_valid_d = s2_valid_q;
      end
      default: begin
        level_d       = combined_q;
        level_valid_d = s2_valid_q;
      end
    endcase
  end

  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      localparam logic [MAG_W-1:0] THR = MAG_W'(gi) << SHIFT;
      assign led_bar_d[gi] = (level_d > THR);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) mag_q[c] <= '0;
      s1_valid_q    <= 1'b0;
      combined_q    <= '0;
      s2_valid_q    <= 1'b0;
      acc_q         <= '0;
      avg_cnt_q     <= '0;
      avg_q         <= '0;
      avg_done_q    <= 1'b0;
      peak_q        <= '0;
      hold_q        <= '0;
      decay_q       <= '0;
      clip_timer_q  <= '0;
      clip_q        <= 1'b0;
      level_q       <= '0;
      led_bar_q     <= '0;
      level_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) mag_q[c] <= mag_comb[c];
      s1_valid_q    <= sample_valid;
      combined_q    <= combined;
      s2_valid_q    <= s1_valid_q;
      acc_q         <= acc_d;
      avg_cnt_q     <= avg_cnt_d;
      avg_q         <= avg_d;
      avg_done_q    <= avg_done_d;
      peak_q        <= peak_d;
      hold_q        <= hold_d;
      decay_q       <= decay_d;
      clip_timer_q  <= clip_timer_d;
      clip_q        <= clip_d;
      level_q       <= level_d;
      led_bar_q     <= led_bar_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign led_bar     = led_bar_q;
  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign clip        = clip_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter with short timing parameters.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic [1:0]  mode = 2'd0;
  logic        peak_clear = 1'b0;
  logic [15:0] led_bar;
  logic [14:0] level;
  logic        level_valid;
  logic        clip;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [14:0] lvl;
    logic [15:0] led;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  audio_level_meter #(
    .SAMPLE_W(16), .CHANNELS(2), .LED_LOG2(4), .AVG_LOG2(2),
    .HOLD_CYCLES(8), .DECAY_PERIOD(4), .DECAY_STEP(1024),
    .CLIP_THRESH(32000), .CLIP_HOLD(30)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .mode(mode), .peak_clear(peak_clear),
    .led_bar(led_bar), .level(level), .level_valid(level_valid), .clip(clip)
  );

  function automatic logic [14:0] ref_mag(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v[14:0];
  endfunction

  function automatic logic [15:0] ref_led(input logic [14:0] lv);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (int'(lv) > i * 2048);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0; peak_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one sample; optional peak_clear lands in that sample's S2 cycle.
  task automatic send(input logic [15:0] c0, input logic [15:0] c1, input logic clr);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = {c1, c0};
    @(negedge clk);
    sample_valid = 1'b0; peak_clear = clr;
    @(negedge clk);
    peak_clear = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!level_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (level !== 15'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++; if (led_bar !== 16'h0) begin failures++; $display("FAIL reset_led got=%h want=0000", led_bar); end
    checks++; if (level_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", level_valid); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got=%b want=0", clip); end
    $display("reset: level=%0d led=%h clip=%b", level, led_bar, clip);
  endtask

  task automatic test_raw();
    int lat;
    do_reset();
    mode = 2'd0;
    send(16'h8000, 16'h0100, 1'b0);
    wait_valid(lat);
    $display("raw fullscale: lat=%0d level=%0d led=%h clip=%b", lat, level, led_bar, clip);
    checks++; if (lat != 1) begin failures++; $display("FAIL raw1_latency got=%0d want=1", lat); end
    checks++; if (level !== 15'd32767) begin failures++; $display("FAIL raw1_level got=%0d want=32767", level); end
    checks++; if (led_bar !== 16'hFFFF) begin failures++; $display("FAIL raw1_led got=%h want=ffff", led_bar); end
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL raw1_clip got=%b want=1", clip); end
    @(negedge clk);
    checks++; if (level_valid !== 1'b0) begin failures++; $display("FAIL raw1_pulse got=%b want=0", level_valid); end

    do_reset();
    send(16'hF7FF, 16'd100, 1'b0);
    wait_valid(lat);
    $display("raw neg: lat=%0d level=%0d led=%h clip=%b", lat, level, led_bar, clip);
    checks++; if (level !== 15'd2049) begin failures++; $display("FAIL raw2_level got=%0d want=2049", level); end
    checks++; if (led_bar !== 16'h0003) begin failures++; $display("FAIL raw2_led got=%h want=0003", led_bar); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL raw2_clip got=%b want=0", clip); end
  endtask

  task automatic test_clip_hold();
    do_reset();
    mode = 2'd0;
    send(16'h7D00, 16'h0000, 1'b0);
    repeat (29) @(negedge clk);
    $display("clip hold: last held cycle clip=%b", clip);
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL clip_held got=%b want=1", clip); end
    @(negedge clk);
    $display("clip hold: expiry cycle clip=%b", clip);
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL clip_expire got=%b want=0", clip); end
  endtask

  task automatic test_average();
    logic [15:0] c0_tab [4];
    int pulses;
    exp_t e;
    c0_tab[0] = 16'd1000; c0_tab[1] = 16'hF830; c0_tab[2] = 16'd3000; c0_tab[3] = 16'hF060;
    do_reset();
    mode = 2'd1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (level_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL avg_unexpected got=pulse want=none");
        end else begin
          e = sb.pop_front();
          $display("avg: level=%0d led=%h", level, led_bar);
          checks++; if (level !== e.lvl) begin failures++; $display("FAIL avg_level got=%0d want=%0d", level, e.lvl); end
          checks++; if (led_bar !== e.led) begin failures++; $display("FAIL avg_led got=%h want=%h", led_bar, e.led); end
        end
      end
      if (i < 4) begin
        sample_valid = 1'b1; sample_data = {16'd500, c0_tab[i]};
        if (i == 3) begin
          e.lvl = 15'd2500; e.led = 16'h0003; sb.push_back(e);
        end
      end else begin
        sample_valid = 1'b0;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL avg_pulses got=%0d want=1", pulses); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL avg_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_peak_decay();
    int lat;
    int ev;
    logic [14:0] evl;
    do_reset();
    mode = 2'd2;
    send(16'd20000, 16'd0, 1'b0);
    wait_valid(lat);
    $display("peak: lat=%0d level=%0d", lat, level);
    checks++; if (level !== 15'd20000) begin failures++; $display("FAIL peak_start got=%0d want=20000", level); end
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k <= 11) ev = 20000;
      else begin
        ev = 20000 - 1024 * ((k - 12) / 4 + 1);
        if (ev < 0) ev = 0;
      end
      evl = ev[14:0];
      checks++; if (level !== evl) begin failures++; $display("FAIL decay_level k=%0d got=%0d want=%0d", k, level, evl); end
      checks++; if (level_valid !== 1'b0) begin failures++; $display("FAIL decay_pulse k=%0d got=%b want=0", k, level_valid); end
      if (k % 4 == 0) $display("decay k=%0d level=%0d", k, level);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    do_reset();
    mode = 2'd2;
    send(16'h8000, 16'h0100, 1'b0);
    wait_valid(lat);
    repeat (3) @(negedge clk);
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL areset_pre_clip got=%b want=1", clip); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    $display("async reset: level=%0d led=%h clip=%b", level, led_bar, clip);
    checks++; if (level !== 15'd0) begin failures++; $display("FAIL areset_level got=%0d want=0", level); end
    checks++; if (led_bar !== 16'h0) begin failures++; $display("FAIL areset_led got=%h want=0000", led_bar); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL areset_clip got=%b want=0", clip); end
    @(negedge clk);
    reset = 1'b0;
    mode = 2'd0;
    send(16'h8000, 16'h0100, 1'b0);
    wait_valid(lat);
    $display("after reset: lat=%0d level=%0d led=%h clip=%b", lat, level, led_bar, clip);
    checks++; if (lat != 1) begin failures++; $display("FAIL areset_lat got=%0d want=1", lat); end
    checks++; if (level !== 15'd32767) begin failures++; $display("FAIL areset_level2 got=%0d want=32767", level); end
    checks++; if (led_bar !== 16'hFFFF) begin failures++; $display("FAIL areset_led2 got=%h want=ffff", led_bar); end
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL areset_clip2 got=%b want=1", clip); end
  endtask

  task automatic test_peak_clear();
    int lat;
    do_reset();
    mode = 2'd2;
    send(16'd20000, 16'd0, 1'b0);
    wait_valid(lat);
    checks++; if (level !== 15'd20000) begin failures++; $display("FAIL pclr_start got=%0d want=20000", level); end
    send(16'd300, 16'hFF38, 1'b1);
    wait_valid(lat);
    $display("peak clear with sample: lat=%0d level=%0d", lat, level);
    checks++; if (level !== 15'd300) begin failures++; $display("FAIL pclr_replace got=%0d want=300", level); end
    repeat (9) @(negedge clk);
    checks++; if (level !== 15'd300) begin failures++; $display("FAIL pclr_hold got=%0d want=300", level); end
    peak_clear = 1'b1;
    @(negedge clk);
    peak_clear = 1'b0;
    @(negedge clk);
    $display("peak clear alone: level=%0d led=%h", level, led_bar);
    checks++; if (level !== 15'd0) begin failures++; $display("FAIL pclr_zero got=%0d want=0", level); end
    checks++; if (led_bar !== 16'h0) begin failures++; $display("FAIL pclr_led got=%h want=0000", led_bar); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] tab0 [10];
    logic [15:0] tab1 [10];
    int pulses;
    exp_t e;
    logic [14:0] m0, m1;
    tab0[0] = 16'h8000; tab1[0] = 16'h0000;
    tab0[1] = 16'h7FFF; tab1[1] = 16'h8001;
    tab0[2] = 16'h0000; tab1[2] = 16'h0000;
    tab0[3] = 16'h0800; tab1[3] = 16'hF801;
    tab0[4] = 16'h0001; tab1[4] = 16'hFFFF;
    tab0[5] = 16'h0801; tab1[5] = 16'h07FF;
    for (int i = 6; i < 10; i++) begin
      tab0[i] = 16'($urandom);
      tab1[i] = 16'($urandom);
    end
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (level_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_unexpected got=pulse want=none");
        end else begin
          e = sb.pop_front();
          $display("b2b: level=%0d led=%h", level, led_bar);
          checks++; if (level !== e.lvl) begin failures++; $display("FAIL b2b_level got=%0d want=%0d", level, e.lvl); end
          checks++; if (led_bar !== e.led) begin failures++; $display("FAIL b2b_led got=%h want=%h", led_bar, e.led); end
        end
      end
      mode = (i < 5) ? 2'd0 : 2'd3;
      if (i < 10) begin
        sample_valid = 1'b1;
        sample_data = {tab1[i], tab0[i]};
        m0 = ref_mag(tab0[i]);
        m1 = ref_mag(tab1[i]);
        e.lvl = (m0 > m1) ? m0 : m1;
        e.led = ref_led(e.lvl);
        sb.push_back(e);
      end else begin
        sample_valid = 1'b0;
      end
    end
    checks++; if (pulses != 10) begin failures++; $display("FAIL b2b_pulses got=%0d want=10", pulses); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_raw();
    test_clip_hold();
    test_average();
    test_peak_decay();
    test_async_reset();
    test_peak_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
